// File: rtl/spi_slave_rdid.sv
// SPI mode-0 slave that answers the RDID opcode with a 24-bit JEDEC ID.
// Define SPI_SLAVE_STATUS_READ_EN to also stream status_in for opcode 8'h05.
`timescale 1ns/1ps
module spi_slave_rdid #(
    parameter logic [23:0] JEDEC_ID    = 24'h202015,
    parameter logic [7:0]  RDID_OPCODE = 8'h9F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic [7:0] inst_opcode,
    output logic       inst_valid,
    output logic       busy,
    input  logic [7:0] status_in
);

    typedef enum logic [2:0] {IDLE, GET_INST, SEND_DATA, IGNORE, WAIT_CS} state_t;

    state_t      state_q, state_d;
    logic [1:0]  sckSync_q, csnSync_q, mosiSync_q;
    logic        sckPrev_q;
    logic [1:0]  settle_q, settle_d;
    logic        armed_q, armed_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  instShift_q, instShift_d;
    logic [23:0] dataShift_q, dataShift_d;
    logic        miso_q, miso_d;
    logic [7:0]  opcode_q, opcode_d;
    logic        valid_q, valid_d;
    logic        sckRise, sckFall, csnHigh;
    logic [7:0]  nextInst;
`ifdef SPI_SLAVE_STATUS_READ_EN
    logic        statusMode_q, statusMode_d;
`else
    logic        unusedStatus;
    assign unusedStatus = ^status_in;
`endif

    assign sckRise  = sckSync_q[1] & ~sckPrev_q;
    assign sckFall  = ~sckSync_q[1] & sckPrev_q;
    assign csnHigh  = csnSync_q[1];
    assign nextInst = {instShift_q[6:0], mosiSync_q[1]};

    // A frame may only start once cs_n has been seen high after the synchronizer
    // has flushed its reset value, so a frame cut by reset is never resumed.
    assign settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    assign armed_d  = armed_q | ((settle_q == 2'd2) & csnHigh);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        instShift_d = instShift_q;
        dataShift_d = dataShift_q;
        miso_d      = miso_q;
        opcode_d    = opcode_q;
        valid_d     = 1'b0;
`ifdef SPI_SLAVE_STATUS_READ_EN
        statusMode_d = statusMode_q;
`endif
        if (state_q != IDLE && csnHigh) begin
            state_d = IDLE;
            miso_d  = 1'b0;
            cnt_d   = 5'd0;
`ifdef SPI_SLAVE_STATUS_READ_EN
            statusMode_d = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    miso_d = 1'b0;
                    if (armed_q && !csnHigh) begin
                        state_d = GET_INST;
                        cnt_d   = 5'd0;
                    end
                end
                GET_INST: begin
                    if (sckRise) begin
                        instShift_d = nextInst;
                        if (cnt_q == 5'd7) begin
                            opcode_d = nextInst;
                            valid_d  = 1'b1;
                            cnt_d    = 5'd0;
                            if (nextInst == RDID_OPCODE) begin
                                state_d     = SEND_DATA;
                                dataShift_d = JEDEC_ID;
`ifdef SPI_SLAVE_STATUS_READ_EN
                                statusMode_d = 1'b0;
                            end else if (nextInst == 8'h05) begin
                                state_d      = SEND_DATA;
                                statusMode_d = 1'b1;
`endif
                            end else begin
                                state_d = IGNORE;
                            end
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                end
                SEND_DATA: begin
                    if (sckFall) begin
`ifdef SPI_SLAVE_STATUS_READ_EN
                        // Status mode reloads a fresh status byte at every byte boundary.
                        if (statusMode_q) begin
                            if (cnt_q[2:0] == 3'd0) begin
                                miso_d      = status_in[7];
                                dataShift_d = {status_in[6:0], 17'b0};
                            end else begin
                                miso_d      = dataShift_q[23];
                                dataShift_d = {dataShift_q[22:0], 1'b0};
                            end
                            cnt_d = {2'b00, cnt_q[2:0] + 3'd1};
                        end else
`endif
                        begin
                            miso_d      = dataShift_q[23];
                            dataShift_d = {dataShift_q[22:0], 1'b0};
                            if (cnt_q == 5'd23) begin
                                state_d = WAIT_CS;
                            end else begin
                                cnt_d = cnt_q + 5'd1;
                            end
                        end
                    end
                end
                WAIT_CS: begin
                    if (sckFall) begin
                        miso_d = 1'b0;
                    end
                end
                IGNORE: begin
                    miso_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    miso_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sckSync_q   <= 2'b00;
            csnSync_q   <= 2'b11;
            mosiSync_q  <= 2'b00;
            sckPrev_q   <= 1'b0;
            settle_q    <= 2'd0;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            instShift_q <= 8'h00;
            dataShift_q <= 24'h000000;
            miso_q      <= 1'b0;
            opcode_q    <= 8'h00;
            valid_q     <= 1'b0;
`ifdef SPI_SLAVE_STATUS_READ_EN
            statusMode_q <= 1'b0;
`endif
        end else begin
            sckSync_q   <= {sckSync_q[0], sck};
            csnSync_q   <= {csnSync_q[0], cs_n};
            mosiSync_q  <= {mosiSync_q[0], mosi};
            sckPrev_q   <= sckSync_q[1];
            settle_q    <= settle_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            instShift_q <= instShift_d;
            dataShift_q <= dataShift_d;
            miso_q      <= miso_d;
            opcode_q    <= opcode_d;
            valid_q     <= valid_d;
`ifdef SPI_SLAVE_STATUS_READ_EN
            statusMode_q <= statusMode_d;
`endif
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = (state_q == SEND_DATA) || (state_q == WAIT_CS);
    assign busy        = (state_q != IDLE);
    assign inst_opcode = opcode_q;
    assign inst_valid  = valid_q;

endmodule
